// File: rtl/rat_multi.sv
`default_nettype none
// ============================================================================
// Module      : rat_multi
// Description : Multi-port register alias table for a superscalar rename
//               stage with in-group bypass, writeback bypass and flush rollback.
// Revision    : 1.0 - initial release
// ============================================================================
module rat_multi #(
    parameter int NREGS    = 32,
    parameter int XLEN     = 32,
    parameter int ROBID_W  = 7,
    parameter int RENAME_W = 2,
    parameter int NWB      = 2,
    parameter int NRET     = 2,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [RENAME_W*AW-1:0]      rename_rs1,
    input  logic [RENAME_W*AW-1:0]      rename_rs2,
    input  logic [RENAME_W-1:0]         rename_alloc,
    input  logic [RENAME_W*AW-1:0]      rename_rd,
    input  logic [RENAME_W*ROBID_W-1:0] rename_robid,
    output logic [RENAME_W-1:0]         rat_rs1_valid,
    output logic [RENAME_W*XLEN-1:0]    rat_rs1_tagval,
    output logic [RENAME_W-1:0]         rat_rs2_valid,
    output logic [RENAME_W*XLEN-1:0]    rat_rs2_tagval,
    input  logic [NWB-1:0]              wb_valid,
    input  logic [NWB-1:0]              wb_error,
    input  logic [NWB*ROBID_W-1:0]      wb_robid,
    input  logic [NWB*(AW+1)-1:0]       wb_rd,
    input  logic [NWB*XLEN-1:0]         wb_result,
    input  logic                        rob_flush,
    input  logic [NRET-1:0]             rob_ret_valid,
    input  logic [NRET*AW-1:0]          rob_ret_rd,
    input  logic [NRET*XLEN-1:0]        rob_ret_result
);

    logic [NREGS-1:0]   r_valid;
    logic [NREGS-1:0]   r_committed;
    logic [ROBID_W-1:0] r_tag      [NREGS];
    logic [XLEN-1:0]    r_spec_val [NREGS];
    logic [XLEN-1:0]    r_comm_val [NREGS];

    logic [AW-1:0]      w_ren_rd     [RENAME_W];
    logic [ROBID_W-1:0] w_ren_robid  [RENAME_W];
    logic [AW:0]        w_wb_rd      [NWB];
    logic [AW-1:0]      w_wb_idx     [NWB];
    logic [ROBID_W-1:0] w_wb_robid   [NWB];
    logic [XLEN-1:0]    w_wb_result  [NWB];
    logic [NWB-1:0]     w_wb_write;
    logic [AW-1:0]      w_ret_rd     [NRET];
    logic [XLEN-1:0]    w_ret_result [NRET];

    generate
        for (genvar j = 0; j < RENAME_W; j++) begin : g_ren_unpack
            assign w_ren_rd[j]    = rename_rd[j*AW +: AW];
            assign w_ren_robid[j] = rename_robid[j*ROBID_W +: ROBID_W];
        end
        for (genvar p = 0; p < NWB; p++) begin : g_wb_unpack
            assign w_wb_rd[p]     = wb_rd[p*(AW+1) +: AW+1];
            assign w_wb_idx[p]    = w_wb_rd[p][AW-1:0];
            assign w_wb_robid[p]  = wb_robid[p*ROBID_W +: ROBID_W];
            assign w_wb_result[p] = wb_result[p*XLEN +: XLEN];
            // Tag match against the pre-update table rejects stale producers.
            assign w_wb_write[p]  = wb_valid[p] & ~wb_error[p] & ~w_wb_rd[p][AW] &
                                    (w_wb_robid[p] == r_tag[w_wb_idx[p]]);
        end
        for (genvar k = 0; k < NRET; k++) begin : g_ret_unpack
            assign w_ret_rd[k]     = rob_ret_rd[k*AW +: AW];
            assign w_ret_result[k] = rob_ret_result[k*XLEN +: XLEN];
        end
    endgenerate

    // Returns {valid, tagval} for one source operand of one rename slot.
    function automatic logic [XLEN:0] f_lookup(input int slot, input logic [AW-1:0] src);
        logic [XLEN:0]   res;
        logic [XLEN-1:0] older_tv;
        logic [XLEN-1:0] wb_val;
        logic [XLEN-1:0] tv;
        logic            older_hit;
        logic            wb_hit;
        res       = '0;
        older_tv  = '0;
        wb_val    = '0;
        tv        = '0;
        older_hit = 1'b0;
        wb_hit    = 1'b0;
        // Later iterations overwrite, so the youngest older slot wins.
        for (int i = 0; i < RENAME_W; i++) begin
            if (i < slot && rename_alloc[i] && w_ren_rd[i] == src && src != '0) begin
                older_tv                 = '0;
                older_tv[ROBID_W-1:0]    = w_ren_robid[i];
                older_hit                = 1'b1;
            end
        end
        for (int p = 0; p < NWB; p++) begin
            if (w_wb_write[p] && w_wb_idx[p] == src) begin
                wb_hit = 1'b1;
                wb_val = w_wb_result[p];
            end
        end
        if (src == '0) begin
            res = {1'b1, {XLEN{1'b0}}};
        end else if (older_hit) begin
            res = {1'b0, older_tv};
        end else if (wb_hit) begin
            res = {1'b1, wb_val};
        end else if (r_committed[src]) begin
            res = {1'b1, r_comm_val[src]};
        end else if (r_valid[src]) begin
            res = {1'b1, r_spec_val[src]};
        end else begin
            tv[ROBID_W-1:0] = r_tag[src];
            res = {1'b0, tv};
        end
        return res;
    endfunction

    generate
        for (genvar j = 0; j < RENAME_W; j++) begin : g_slot
            logic [XLEN:0] w_rs1_res;
            logic [XLEN:0] w_rs2_res;
            always_comb begin
                w_rs1_res = f_lookup(j, rename_rs1[j*AW +: AW]);
                w_rs2_res = f_lookup(j, rename_rs2[j*AW +: AW]);
            end
            assign rat_rs1_valid[j]               = w_rs1_res[XLEN];
            assign rat_rs1_tagval[j*XLEN +: XLEN] = w_rs1_res[XLEN-1:0];
            assign rat_rs2_valid[j]               = w_rs2_res[XLEN];
            assign rat_rs2_tagval[j*XLEN +: XLEN] = w_rs2_res[XLEN-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= '1;
            r_committed <= '1;
            for (int r = 0; r < NREGS; r++) begin
                r_tag[r]      <= '0;
                r_spec_val[r] <= '0;
                r_comm_val[r] <= '0;
            end
        end else begin
            if (rob_flush) begin
                r_valid     <= '1;
                r_committed <= '1;
            end else begin
                for (int p = 0; p < NWB; p++) begin
                    if (w_wb_write[p]) begin
                        r_valid[w_wb_idx[p]]    <= 1'b1;
                        r_spec_val[w_wb_idx[p]] <= w_wb_result[p];
                    end
                end
                // Placed after writeback so a same-cycle alloc clears valid.
                for (int j = 0; j < RENAME_W; j++) begin
                    if (rename_alloc[j] && w_ren_rd[j] != '0) begin
                        r_tag[w_ren_rd[j]]       <= w_ren_robid[j];
                        r_valid[w_ren_rd[j]]     <= 1'b0;
                        r_committed[w_ren_rd[j]] <= 1'b0;
                    end
                end
            end
            for (int k = 0; k < NRET; k++) begin
                if (rob_ret_valid[k] && w_ret_rd[k] != '0) begin
                    r_comm_val[w_ret_rd[k]] <= w_ret_result[k];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rat_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_rat_multi
// Description : Self-checking bench for rat_multi with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rat_multi;
    localparam int NREGS = 32, AW = 5, XLEN = 32, ROBID_W = 7;
    localparam int RW = 2, NWB = 2, NRET = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic [RW*AW-1:0]       rename_rs1, rename_rs2, rename_rd;
    logic [RW-1:0]          rename_alloc;
    logic [RW*ROBID_W-1:0]  rename_robid;
    logic [RW-1:0]          rat_rs1_valid, rat_rs2_valid;
    logic [RW*XLEN-1:0]     rat_rs1_tagval, rat_rs2_tagval;
    logic [NWB-1:0]         wb_valid, wb_error;
    logic [NWB*ROBID_W-1:0] wb_robid;
    logic [NWB*(AW+1)-1:0]  wb_rd;
    logic [NWB*XLEN-1:0]    wb_result;
    logic                   rob_flush;
    logic [NRET-1:0]        rob_ret_valid;
    logic [NRET*AW-1:0]     rob_ret_rd;
    logic [NRET*XLEN-1:0]   rob_ret_result;

    rat_multi #(.NREGS(NREGS), .XLEN(XLEN), .ROBID_W(ROBID_W),
                .RENAME_W(RW), .NWB(NWB), .NRET(NRET)) dut (
        .clk(clk), .rst(rst),
        .rename_rs1(rename_rs1), .rename_rs2(rename_rs2),
        .rename_alloc(rename_alloc), .rename_rd(rename_rd), .rename_robid(rename_robid),
        .rat_rs1_valid(rat_rs1_valid), .rat_rs1_tagval(rat_rs1_tagval),
        .rat_rs2_valid(rat_rs2_valid), .rat_rs2_tagval(rat_rs2_tagval),
        .wb_valid(wb_valid), .wb_error(wb_error), .wb_robid(wb_robid),
        .wb_rd(wb_rd), .wb_result(wb_result), .rob_flush(rob_flush),
        .rob_ret_valid(rob_ret_valid), .rob_ret_rd(rob_ret_rd),
        .rob_ret_result(rob_ret_result)
    );

    // Stimulus in unpacked form
    logic               s_rst, s_flush;
    logic [AW-1:0]      s_rs1 [RW], s_rs2 [RW], s_rd [RW];
    logic               s_alloc [RW];
    logic [ROBID_W-1:0] s_robid [RW];
    logic               s_wbv [NWB], s_wbe [NWB];
    logic [ROBID_W-1:0] s_wbrobid [NWB];
    logic [AW:0]        s_wbrd [NWB];
    logic [XLEN-1:0]    s_wbres [NWB];
    logic               s_retv [NRET];
    logic [AW-1:0]      s_retrd [NRET];
    logic [XLEN-1:0]    s_retres [NRET];

    always_comb begin
        rst = s_rst;
        rob_flush = s_flush;
        rename_rs1 = '0; rename_rs2 = '0; rename_rd = '0; rename_alloc = '0; rename_robid = '0;
        wb_valid = '0; wb_error = '0; wb_robid = '0; wb_rd = '0; wb_result = '0;
        rob_ret_valid = '0; rob_ret_rd = '0; rob_ret_result = '0;
        for (int j = 0; j < RW; j++) begin
            rename_rs1[j*AW +: AW] = s_rs1[j];
            rename_rs2[j*AW +: AW] = s_rs2[j];
            rename_rd[j*AW +: AW]  = s_rd[j];
            rename_alloc[j]        = s_alloc[j];
            rename_robid[j*ROBID_W +: ROBID_W] = s_robid[j];
        end
        for (int p = 0; p < NWB; p++) begin
            wb_valid[p] = s_wbv[p];
            wb_error[p] = s_wbe[p];
            wb_robid[p*ROBID_W +: ROBID_W] = s_wbrobid[p];
            wb_rd[p*(AW+1) +: AW+1]        = s_wbrd[p];
            wb_result[p*XLEN +: XLEN]      = s_wbres[p];
        end
        for (int k = 0; k < NRET; k++) begin
            rob_ret_valid[k] = s_retv[k];
            rob_ret_rd[k*AW +: AW] = s_retrd[k];
            rob_ret_result[k*XLEN +: XLEN] = s_retres[k];
        end
    end

    // Reference model state
    bit                 m_valid [NREGS], m_comm [NREGS], m_known [NREGS];
    logic [ROBID_W-1:0] m_tag  [NREGS];
    logic [XLEN-1:0]    m_spec [NREGS], m_cval [NREGS];
    bit                 m_init = 1'b0;
    int unsigned        next_robid = 0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN:0] tagv(input logic [ROBID_W-1:0] t);
        return {1'b0, {(XLEN-ROBID_W){1'b0}}, t};
    endfunction

    function automatic logic [XLEN:0] val(input logic [XLEN-1:0] v);
        return {1'b1, v};
    endfunction

    function automatic bit m_wbw(input int p);
        return s_wbv[p] && !s_wbe[p] && !s_wbrd[p][AW] &&
               (s_wbrobid[p] == m_tag[s_wbrd[p][AW-1:0]]);
    endfunction

    function automatic logic [XLEN:0] m_read(input int j, input logic [AW-1:0] s);
        if (s == 0) return val(0);
        for (int i = j - 1; i >= 0; i--)
            if (s_alloc[i] && s_rd[i] == s) return tagv(s_robid[i]);
        for (int p = 0; p < NWB; p++)
            if (m_wbw(p) && s_wbrd[p] == {1'b0, s}) return val(s_wbres[p]);
        if (m_comm[s])  return val(m_cval[s]);
        if (m_valid[s]) return val(m_spec[s]);
        return tagv(m_tag[s]);
    endfunction

    function automatic logic [XLEN:0] obs_rd(input int j, input bit second);
        if (second) return {rat_rs2_valid[j], rat_rs2_tagval[j*XLEN +: XLEN]};
        return {rat_rs1_valid[j], rat_rs1_tagval[j*XLEN +: XLEN]};
    endfunction

    task automatic model_update;
        bit wbw [NWB];
        if (s_rst) begin
            for (int r = 0; r < NREGS; r++) begin
                m_valid[r] = 1; m_comm[r] = 1; m_cval[r] = 0; m_known[r] = 0;
            end
            m_init = 1'b1;
            return;
        end
        for (int p = 0; p < NWB; p++) wbw[p] = m_wbw(p);
        if (s_flush) begin
            for (int r = 0; r < NREGS; r++) begin m_valid[r] = 1; m_comm[r] = 1; end
        end else begin
            for (int p = 0; p < NWB; p++)
                if (wbw[p]) begin
                    m_valid[s_wbrd[p][AW-1:0]] = 1;
                    m_spec[s_wbrd[p][AW-1:0]]  = s_wbres[p];
                end
            for (int j = 0; j < RW; j++)
                if (s_alloc[j] && s_rd[j] != 0) begin
                    m_tag[s_rd[j]] = s_robid[j];
                    m_valid[s_rd[j]] = 0; m_comm[s_rd[j]] = 0; m_known[s_rd[j]] = 1;
                end
        end
        for (int k = 0; k < NRET; k++)
            if (s_retv[k] && s_retrd[k] != 0) m_cval[s_retrd[k]] = s_retres[k];
    endtask

    task automatic clear_inputs;
        s_rst = 0; s_flush = 0;
        for (int j = 0; j < RW; j++) begin
            s_rs1[j] = 0; s_rs2[j] = 0; s_rd[j] = 0; s_alloc[j] = 0; s_robid[j] = 0;
        end
        for (int p = 0; p < NWB; p++) begin
            s_wbv[p] = 0; s_wbe[p] = 0; s_wbrobid[p] = 0; s_wbrd[p] = 0; s_wbres[p] = 0;
        end
        for (int k = 0; k < NRET; k++) begin
            s_retv[k] = 0; s_retrd[k] = 0; s_retres[k] = 0;
        end
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    task automatic step;
        if (m_init) begin
            for (int j = 0; j < RW; j++) begin
                chk($sformatf("model_rs1_s%0d_r%0d", j, s_rs1[j]), 64'(obs_rd(j, 0)), 64'(m_read(j, s_rs1[j])));
                chk($sformatf("model_rs2_s%0d_r%0d", j, s_rs2[j]), 64'(obs_rd(j, 1)), 64'(m_read(j, s_rs2[j])));
            end
        end
        model_update();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic rand_inputs;
        int q[$];
        q = {};
        for (int r = 1; r < NREGS; r++) if (m_known[r]) q.push_back(r);
        s_rst   = ($urandom_range(0, 199) == 0);
        s_flush = ($urandom_range(0, 19) == 0);
        for (int j = 0; j < RW; j++) begin
            s_rs1[j]   = AW'($urandom_range(0, 7));
            s_rs2[j]   = AW'($urandom_range(0, 7));
            s_alloc[j] = ($urandom_range(0, 2) != 0);
            s_rd[j]    = AW'($urandom_range(0, 7));
            s_robid[j] = ROBID_W'(next_robid);
            next_robid++;
        end
        for (int p = 0; p < NWB; p++) begin
            if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
                int r;
                r = q[$urandom_range(0, q.size() - 1)];
                s_wbv[p]     = 1;
                s_wbrd[p]    = {1'b0, AW'(r)};
                s_wbrobid[p] = ($urandom_range(0, 3) != 0) ? m_tag[r] : ROBID_W'($urandom_range(0, 127));
                s_wbe[p]     = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 9) == 0) s_wbrd[p][AW] = 1'b1;
                s_wbres[p]   = $urandom;
            end
        end
        // Two ports never carry the same producer tag for the same register.
        if (s_wbv[0] && s_wbv[1] && s_wbrd[0][AW-1:0] == s_wbrd[1][AW-1:0] &&
            s_wbrobid[0] == s_wbrobid[1])
            s_wbrobid[1] = s_wbrobid[1] + 1'b1;
        for (int k = 0; k < NRET; k++) begin
            s_retv[k]   = ($urandom_range(0, 1) != 0);
            s_retrd[k]  = AW'($urandom_range(0, 7));
            s_retres[k] = $urandom;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        #1;
        s_rst = 1; settle(); step();
        s_rst = 1; settle(); step();

        // Reset state reads
        for (int j = 0; j < RW; j++) begin s_rs1[j] = 5; s_rs2[j] = 0; end
        settle();
        for (int j = 0; j < RW; j++) begin
            chk($sformatf("rst_rs1_s%0d", j), 64'(obs_rd(j, 0)), 64'(val(0)));
            chk($sformatf("rst_rs2_s%0d", j), 64'(obs_rd(j, 1)), 64'(val(0)));
        end
        step();

        // In-group dependency
        s_alloc[0] = 1; s_rd[0] = 3; s_robid[0] = 9; s_rs1[1] = 3;
        settle(); chk("ingroup_dep", 64'(obs_rd(1, 0)), 64'(tagv(9))); step();
        s_rs1[0] = 3;
        settle(); chk("tag_next_cycle", 64'(obs_rd(0, 0)), 64'(tagv(9))); step();

        // Writeback bypass and stale writeback
        s_rs1[0] = 3; s_wbv[1] = 1; s_wbrobid[1] = 9; s_wbrd[1] = 6'd3; s_wbres[1] = 32'hDEAD;
        settle(); chk("wb_bypass", 64'(obs_rd(0, 0)), 64'(val(32'hDEAD))); step();
        s_rs1[0] = 3; s_wbv[0] = 1; s_wbrobid[0] = 8; s_wbrd[0] = 6'd3; s_wbres[0] = 32'hBEEF;
        settle(); chk("wb_stale_bypass", 64'(obs_rd(0, 0)), 64'(val(32'hDEAD))); step();
        s_rs1[0] = 3;
        settle(); chk("wb_stale_state", 64'(obs_rd(0, 0)), 64'(val(32'hDEAD))); step();

        // Retire ordering and flush rollback
        s_alloc[0] = 1; s_rd[0] = 4; s_robid[0] = 12;
        settle(); step();
        s_flush = 1;
        s_retv[0] = 1; s_retrd[0] = 4; s_retres[0] = 32'h11;
        s_retv[1] = 1; s_retrd[1] = 4; s_retres[1] = 32'h55;
        s_alloc[0] = 1; s_rd[0] = 5; s_robid[0] = 20;
        settle(); step();
        s_rs1[0] = 4; s_rs2[0] = 5;
        settle();
        chk("flush_ret_val", 64'(obs_rd(0, 0)), 64'(val(32'h55)));
        chk("flush_alloc_ignored", 64'(obs_rd(0, 1)), 64'(val(0)));
        step();

        // x0 alloc and same-rd allocs in one group
        s_alloc[0] = 1; s_rd[0] = 0; s_robid[0] = 30;
        s_alloc[1] = 1; s_rd[1] = 7; s_robid[1] = 2;
        settle(); step();
        s_rs1[0] = 0;
        s_alloc[0] = 1; s_rd[0] = 7; s_robid[0] = 2;
        s_alloc[1] = 1; s_rd[1] = 7; s_robid[1] = 3;
        settle(); chk("x0_read", 64'(obs_rd(0, 0)), 64'(val(0))); step();
        s_rs1[0] = 7; s_wbv[0] = 1; s_wbrobid[0] = 2; s_wbrd[0] = 6'd7; s_wbres[0] = 32'h1234;
        settle(); chk("same_rd_high_wins", 64'(obs_rd(0, 0)), 64'(tagv(3))); step();
        s_rs1[0] = 7;
        settle(); chk("old_tag_wb_ignored", 64'(obs_rd(0, 0)), 64'(tagv(3))); step();

        // Faulting and no-destination writebacks
        s_rs1[0] = 7; s_wbv[0] = 1; s_wbe[0] = 1; s_wbrobid[0] = 3; s_wbrd[0] = 6'd7; s_wbres[0] = 32'h77;
        settle(); chk("wb_error_bypass", 64'(obs_rd(0, 0)), 64'(tagv(3))); step();
        s_rs1[0] = 7; s_wbv[1] = 1; s_wbrobid[1] = 3; s_wbrd[1] = 6'b100111; s_wbres[1] = 32'h88;
        settle(); chk("wb_nodest_bypass", 64'(obs_rd(0, 0)), 64'(tagv(3))); step();
        s_rs1[0] = 7;
        settle(); chk("wb_fault_state", 64'(obs_rd(0, 0)), 64'(tagv(3))); step();
        s_rs1[1] = 7; s_wbv[0] = 1; s_wbrobid[0] = 3; s_wbrd[0] = 6'd7; s_wbres[0] = 32'h99;
        settle(); chk("wb_good_bypass", 64'(obs_rd(1, 0)), 64'(val(32'h99))); step();
        s_rs2[1] = 7;
        settle(); chk("wb_good_state", 64'(obs_rd(1, 1)), 64'(val(32'h99))); step();

        // Reset mid-stream beats concurrent traffic
        s_rst = 1; s_alloc[0] = 1; s_rd[0] = 6; s_robid[0] = 40;
        s_retv[0] = 1; s_retrd[0] = 6; s_retres[0] = 32'hAB;
        settle(); step();
        s_rs1[0] = 6; s_rs2[0] = 4;
        settle();
        chk("rst_over_alloc", 64'(obs_rd(0, 0)), 64'(val(0)));
        chk("rst_clears_comm", 64'(obs_rd(0, 1)), 64'(val(0)));
        step();

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            rand_inputs();
            settle();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
